// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and mode constants for the SPI slave transmitter
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } spi_tx_state_e;

   localparam int SPI_CPOL = 0;
   localparam int SPI_CPHA = 0;

endpackage

// File: rtl/spi_edge_sync.sv
// rtl/spi_edge_sync.sv - synchronizer for one async SPI pin with rise/fall strobes
module spi_edge_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              hist_q;
   logic              level;

   // Reset to 0: a spurious rise after reset only lands in IDLE where it is ignored,
   // and a select held low across reset never looks like a new frame start.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_i};
         hist_q <= sync_q[STAGES-1];
      end
   end

   assign level  = sync_q[STAGES-1];
   assign rise_o = level & ~hist_q;
   assign fall_o = ~level & hist_q;

endmodule

// File: rtl/spi_slave_tx.sv
// rtl/spi_slave_tx.sv - SPI mode 0 slave transmitter, MSB first, one-word holding buffer
module spi_slave_tx
   import spi_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 512,
   parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = '0,
   parameter int                    SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sclk,
   input  logic                  ss_n,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic                  miso,
   output logic                  miso_oe,
   output logic                  tx_done,
   output logic                  underrun,
   output logic                  abort
);

   localparam int            CW       = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   logic sclk_rise, sclk_fall, ss_rise, ss_fall;

   spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
      .clk_i   (clk),
      .rst_i   (rst),
      .async_i (sclk),
      .rise_o  (sclk_rise),
      .fall_o  (sclk_fall)
   );

   spi_edge_sync #(.STAGES(SYNC_STAGES)) u_ss_sync (
      .clk_i   (clk),
      .rst_i   (rst),
      .async_i (ss_n),
      .rise_o  (ss_rise),
      .fall_o  (ss_fall)
   );

   spi_tx_state_e         state_q, state_d;
   logic [DATA_WIDTH-1:0] buf_q, buf_d;
   logic                  buf_full_q, buf_full_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
   logic                  tx_done_q, tx_done_d;
   logic                  underrun_q, underrun_d;
   logic                  abort_q, abort_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         tx_done_q  <= 1'b0;
         underrun_q <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_done_q  <= tx_done_d;
         underrun_q <= underrun_d;
         abort_q    <= abort_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      tx_done_d  = 1'b0;
      underrun_d = 1'b0;
      abort_d    = 1'b0;

      // Load and take are exclusive: load needs an empty buffer, take needs a full one.
      if (tx_valid && !buf_full_q) begin
         buf_d      = tx_data;
         buf_full_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (ss_fall) begin
               if (buf_full_q) begin
                  shift_d    = buf_q;
                  buf_full_d = 1'b0;
               end else begin
                  shift_d    = IDLE_WORD;
                  underrun_d = 1'b1;
               end
               bit_cnt_d = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            if (ss_rise) begin
               abort_d = 1'b1;
               state_d = IDLE;
            end else if (sclk_rise) begin
               bit_cnt_d = bit_cnt_q + CW'(1);
               if (bit_cnt_q == LAST_BIT) begin
                  tx_done_d = 1'b1;
                  state_d   = DONE;
               end
            end else if (sclk_fall && bit_cnt_q != '0) begin
               shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
            end
         end
         DONE: begin
            if (ss_rise) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign tx_ready = ~buf_full_q;
   assign miso     = (state_q == SHIFT) & shift_q[DATA_WIDTH-1];
   assign miso_oe  = (state_q != IDLE);
   assign tx_done  = tx_done_q;
   assign underrun = underrun_q;
   assign abort    = abort_q;

endmodule

// File: tb/tb_spi_slave_tx.sv
// tb/tb_spi_slave_tx.sv - directed bench: 8-bit and 512-bit slaves on one shared SPI master
module tb_spi_slave_tx;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         sclk = 1'b0;
   logic         ss_n = 1'b1;
   logic [7:0]   tx_data_n = '0;
   logic         tx_valid_n = 1'b0;
   logic         tx_ready_n, miso_n, miso_oe_n, tx_done_n, underrun_n, abort_n;
   logic [511:0] tx_data_w = '0;
   logic         tx_valid_w = 1'b0;
   logic         tx_ready_w, miso_w, miso_oe_w, tx_done_w, underrun_w, abort_w;

   int checks = 0;
   int errors = 0;
   int done_cnt_n = 0, under_cnt_n = 0, abort_cnt_n = 0, done_cnt_w = 0;

   always #10 clk = ~clk;

   spi_slave_tx #(.DATA_WIDTH(8)) u_dut_n (
      .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n),
      .tx_data(tx_data_n), .tx_valid(tx_valid_n), .tx_ready(tx_ready_n),
      .miso(miso_n), .miso_oe(miso_oe_n), .tx_done(tx_done_n),
      .underrun(underrun_n), .abort(abort_n)
   );

   spi_slave_tx #(.DATA_WIDTH(512)) u_dut_w (
      .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n),
      .tx_data(tx_data_w), .tx_valid(tx_valid_w), .tx_ready(tx_ready_w),
      .miso(miso_w), .miso_oe(miso_oe_w), .tx_done(tx_done_w),
      .underrun(underrun_w), .abort(abort_w)
   );

   always @(posedge clk) begin
      if (tx_done_n)  done_cnt_n  <= done_cnt_n + 1;
      if (underrun_n) under_cnt_n <= under_cnt_n + 1;
      if (abort_n)    abort_cnt_n <= abort_cnt_n + 1;
      if (tx_done_w)  done_cnt_w  <= done_cnt_w + 1;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic load(input bit wide, input logic [511:0] w);
      if (wide) begin
         tx_data_w  = w;
         tx_valid_w = 1'b1;
      end else begin
         tx_data_n  = w[7:0];
         tx_valid_n = 1'b1;
      end
      wait_clk(1);
      tx_valid_w = 1'b0;
      tx_valid_n = 1'b0;
   endtask

   task automatic sclk_pulse();
      sclk = 1'b1;
      wait_clk(5);
      sclk = 1'b0;
      wait_clk(5);
   endtask

   // Mode 0 master: miso sampled just before each rising sclk edge, MSB first.
   task automatic frame(input int nbits, input int stop_at, input bit wide, input bit q_en,
                        input logic [511:0] q_word, output logic [511:0] rx, output logic rdy0);
      rx   = '0;
      rdy0 = 1'b0;
      ss_n = 1'b0;
      wait_clk(5);
      for (int i = 0; i < nbits; i++) begin
         if (i == stop_at) break;
         if (i == 0) rdy0 = wide ? tx_ready_w : tx_ready_n;
         if (i == 1 && q_en) load(wide, q_word);
         rx = {rx[510:0], wide ? miso_w : miso_n};
         sclk_pulse();
      end
      ss_n = 1'b1;
      wait_clk(10);
   endtask

   logic [511:0] rx;
   logic         rdy0;
   int           d0, u0, a0, dw0;

   initial begin
      wait_clk(3);
      rst = 1'b0;
      wait_clk(2);
      chk("reset_tx_ready", tx_ready_n, 1);
      chk("reset_miso", miso_n, 0);
      chk("reset_miso_oe", miso_oe_n, 0);
      chk("reset_tx_done", tx_done_n, 0);

      // 1: buffered word A5
      d0 = done_cnt_n; u0 = under_cnt_n;
      load(0, 8'hA5);
      chk("t1_ready_after_load", tx_ready_n, 0);
      frame(8, -1, 0, 0, '0, rx, rdy0);
      chk("t1_rx", rx[7:0], 8'hA5);
      chk("t1_ready_after_ss_fall", rdy0, 1);
      chk("t1_done_pulses", done_cnt_n - d0, 1);
      chk("t1_no_underrun", under_cnt_n - u0, 0);
      chk("t1_oe_idle", miso_oe_n, 0);

      // 2: empty buffer -> IDLE_WORD
      d0 = done_cnt_n; u0 = under_cnt_n;
      frame(8, -1, 0, 0, '0, rx, rdy0);
      chk("t2_rx", rx[7:0], 8'h00);
      chk("t2_underrun", under_cnt_n - u0, 1);
      chk("t2_done_pulses", done_cnt_n - d0, 1);

      // 3: queue next word mid-frame
      load(0, 8'h3C);
      frame(8, -1, 0, 1, 512'hC3, rx, rdy0);
      chk("t3_rx_first", rx[7:0], 8'h3C);
      chk("t3_ready_at_ss_fall", rdy0, 1);
      chk("t3_ready_buffered", tx_ready_n, 0);
      frame(8, -1, 0, 0, '0, rx, rdy0);
      chk("t3_rx_second", rx[7:0], 8'hC3);
      chk("t3_ready_end", tx_ready_n, 1);

      // 4: abort after 4 bits of F0; remainder must not be resent
      d0 = done_cnt_n; a0 = abort_cnt_n;
      load(0, 8'hF0);
      frame(8, 4, 0, 0, '0, rx, rdy0);
      chk("t4_rx_partial", rx[3:0], 4'hF);
      chk("t4_abort", abort_cnt_n - a0, 1);
      chk("t4_no_done", done_cnt_n - d0, 0);
      u0 = under_cnt_n;
      frame(8, -1, 0, 0, '0, rx, rdy0);
      chk("t4_rx_next", rx[7:0], 8'h00);
      chk("t4_next_underrun", under_cnt_n - u0, 1);

      // 5: reset after 3 bits of 81
      load(0, 8'h81);
      ss_n = 1'b0;
      wait_clk(5);
      for (int i = 0; i < 3; i++) sclk_pulse();
      chk("t5_oe_before_rst", miso_oe_n, 1);
      rst = 1'b1;
      wait_clk(1);
      rst = 1'b0;
      chk("t5_miso", miso_n, 0);
      chk("t5_miso_oe", miso_oe_n, 0);
      chk("t5_tx_ready", tx_ready_n, 1);
      ss_n = 1'b1;
      wait_clk(10);
      u0 = under_cnt_n;
      frame(8, -1, 0, 0, '0, rx, rdy0);
      chk("t5_rx_next", rx[7:0], 8'h00);
      chk("t5_next_underrun", under_cnt_n - u0, 1);

      // 6: 512-bit frames back to back
      dw0 = done_cnt_w;
      load(1, 512'h35);
      frame(512, -1, 1, 1, 512'h44, rx, rdy0);
      chk("t6_rx_first", rx, 512'h35);
      frame(512, -1, 1, 0, '0, rx, rdy0);
      chk("t6_rx_second", rx, 512'h44);
      chk("t6_done_pulses", done_cnt_w - dw0, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
